// File: rtl/tmds_rx_decoder.sv
// TMDS receive lane: bit-serial deserialiser, control-token word alignment and 10b->8b decode.
// Optional feature macro: TMDS_RX_DISP_CHECK_EN adds the dispErr running-disparity status output.
module tmds_rx_decoder #(
    parameter int LOCK_COUNT = 8,
    parameter int TIMEOUT    = 1023
) (
    input  logic       clkPixel,
    input  logic       rstN,
    input  logic       serIn,
    output logic       valid,
    output logic       de,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic       locked,
    output logic       errFlag
`ifdef TMDS_RX_DISP_CHECK_EN
    ,
    output logic       dispErr
`endif
);
    localparam int TCW = $clog2(LOCK_COUNT + 1);
    localparam int OCW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t         state_r, state_nxt_s;
    logic [9:0]     sr_r;
    logic [3:0]     bit_phase_r, bit_phase_nxt_s;
    logic [TCW-1:0] tok_cnt_r, tok_cnt_nxt_s;
    logic [OCW-1:0] tmo_cnt_r, tmo_cnt_nxt_s;
    logic           is_tok_s;
    logic [1:0]     tok_code_s;
    logic           boundary_s;
    logic           strobe_s;
    logic           err_s;
    logic [7:0]     dec_s;
    logic           valid_r, de_r, locked_r, err_r;
    logic [7:0]     data_r;
    logic [1:0]     ctrl_r;

    function automatic logic [7:0] tmds_decode(input logic [9:0] c);
        logic [7:0] d;
        logic [7:0] o;
        d    = c[9] ? ~c[7:0] : c[7:0];
        o[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            o[i] = c[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return o;
    endfunction

    assign boundary_s = (bit_phase_r == 4'd9);
    assign dec_s      = tmds_decode(sr_r);

    // Control-token recogniser on the current 10-bit window
    always_comb begin
        is_tok_s   = 1'b1;
        tok_code_s = 2'b00;
        case (sr_r)
            10'b1101010100: tok_code_s = 2'b00;
            10'b0010101011: tok_code_s = 2'b01;
            10'b0101010100: tok_code_s = 2'b10;
            10'b1010101011: tok_code_s = 2'b11;
            default:        is_tok_s   = 1'b0;
        endcase
    end

    // Alignment FSM next-state, counters and strobe/error decisions
    always_comb begin
        state_nxt_s     = state_r;
        tok_cnt_nxt_s   = tok_cnt_r;
        tmo_cnt_nxt_s   = tmo_cnt_r;
        bit_phase_nxt_s = boundary_s ? 4'd0 : bit_phase_r + 4'd1;
        strobe_s        = 1'b0;
        err_s           = 1'b0;
        case (state_r)
            HUNT: begin
                // A token seen here defines this clock as a boundary, so the next one is 10 clocks on
                if (is_tok_s) begin
                    state_nxt_s     = VERIFY;
                    tok_cnt_nxt_s   = TCW'(1);
                    bit_phase_nxt_s = 4'd0;
                end else begin
                    tok_cnt_nxt_s   = {TCW{1'b0}};
                end
            end
            VERIFY: begin
                if (boundary_s && is_tok_s) begin
                    tok_cnt_nxt_s = tok_cnt_r + TCW'(1);
                    if (tok_cnt_r == TCW'(LOCK_COUNT - 1)) begin
                        state_nxt_s   = LOCKED;
                        strobe_s      = 1'b1;
                        tmo_cnt_nxt_s = {OCW{1'b0}};
                    end else begin
                        state_nxt_s   = VERIFY;
                    end
                end else if (boundary_s) begin
                    state_nxt_s   = HUNT;
                    err_s         = 1'b1;
                    tok_cnt_nxt_s = {TCW{1'b0}};
                end else begin
                    state_nxt_s   = VERIFY;
                end
            end
            LOCKED: begin
                if (boundary_s) begin
                    strobe_s = 1'b1;
                    if (is_tok_s) begin
                        tmo_cnt_nxt_s = {OCW{1'b0}};
                    end else if (tmo_cnt_r >= OCW'(TIMEOUT - 1)) begin
                        tmo_cnt_nxt_s = OCW'(TIMEOUT);
                        state_nxt_s   = HUNT;
                        err_s         = 1'b1;
                    end else begin
                        tmo_cnt_nxt_s = tmo_cnt_r + OCW'(1);
                    end
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: begin
                state_nxt_s   = HUNT;
                tok_cnt_nxt_s = {TCW{1'b0}};
                tmo_cnt_nxt_s = {OCW{1'b0}};
            end
        endcase
    end

    // Shift register, bit phase, FSM state and counters
    always_ff @(posedge clkPixel) begin
        if (!rstN) begin
            sr_r        <= 10'd0;
            bit_phase_r <= 4'd0;
            state_r     <= HUNT;
            tok_cnt_r   <= {TCW{1'b0}};
            tmo_cnt_r   <= {OCW{1'b0}};
        end else begin
            sr_r        <= {serIn, sr_r[9:1]};
            bit_phase_r <= bit_phase_nxt_s;
            state_r     <= state_nxt_s;
            tok_cnt_r   <= tok_cnt_nxt_s;
            tmo_cnt_r   <= tmo_cnt_nxt_s;
        end
    end

    // Registered character outputs; ctrl holds across data, data is zero on tokens
    always_ff @(posedge clkPixel) begin
        if (!rstN) begin
            valid_r  <= 1'b0;
            de_r     <= 1'b0;
            data_r   <= 8'd0;
            ctrl_r   <= 2'b00;
            locked_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            valid_r  <= strobe_s;
            err_r    <= err_s;
            locked_r <= (state_nxt_s == LOCKED);
            if (strobe_s && is_tok_s) begin
                de_r   <= 1'b0;
                data_r <= 8'd0;
                ctrl_r <= tok_code_s;
            end else if (strobe_s) begin
                de_r   <= 1'b1;
                data_r <= dec_s;
            end else begin
                de_r   <= de_r;
                data_r <= data_r;
            end
        end
    end

    assign valid   = valid_r;
    assign de      = de_r;
    assign data    = data_r;
    assign ctrl    = ctrl_r;
    assign locked  = locked_r;
    assign errFlag = err_r;

`ifdef TMDS_RX_DISP_CHECK_EN
    logic [7:0]        qm_s;
    logic [3:0]        n1_q_s, n1_d_s;
    logic signed [5:0] diff_s, disp_cnt_r, disp_cnt_nxt_s;
    logic              exp_qm8_s, exp_q9_s, disp_mis_s, disp_err_r;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Re-run the encoder's q[8]/q[9] choice on the decoded byte and the running disparity
    always_comb begin
        qm_s      = sr_r[9] ? ~sr_r[7:0] : sr_r[7:0];
        n1_q_s    = ones8(qm_s);
        n1_d_s    = ones8(dec_s);
        diff_s    = $signed({1'b0, n1_q_s, 1'b0}) - 6'sd8;
        exp_qm8_s = !((n1_d_s > 4'd4) || ((n1_d_s == 4'd4) && !dec_s[0]));
        if ((disp_cnt_r == 6'sd0) || (n1_q_s == 4'd4)) begin
            exp_q9_s       = ~sr_r[8];
            disp_cnt_nxt_s = sr_r[8] ? disp_cnt_r + diff_s : disp_cnt_r - diff_s;
        end else if (((disp_cnt_r > 6'sd0) && (n1_q_s > 4'd4)) ||
                     ((disp_cnt_r < 6'sd0) && (n1_q_s < 4'd4))) begin
            exp_q9_s       = 1'b1;
            disp_cnt_nxt_s = disp_cnt_r + (sr_r[8] ? 6'sd2 : 6'sd0) - diff_s;
        end else begin
            exp_q9_s       = 1'b0;
            disp_cnt_nxt_s = disp_cnt_r - (sr_r[8] ? 6'sd0 : 6'sd2) + diff_s;
        end
        disp_mis_s = (exp_qm8_s != sr_r[8]) || (exp_q9_s != sr_r[9]);
    end

    // Running disparity state and the dispErr strobe
    always_ff @(posedge clkPixel) begin
        if (!rstN) begin
            disp_cnt_r <= 6'sd0;
            disp_err_r <= 1'b0;
        end else if (strobe_s && is_tok_s) begin
            disp_cnt_r <= 6'sd0;
            disp_err_r <= 1'b0;
        end else if (strobe_s) begin
            disp_cnt_r <= disp_cnt_nxt_s;
            disp_err_r <= disp_mis_s;
        end else begin
            disp_cnt_r <= disp_cnt_r;
            disp_err_r <= 1'b0;
        end
    end

    assign dispErr = disp_err_r;
`endif

endmodule
